// File: rtl/wb_gpio_irq_if.sv
// Wishbone pipelined bus bundle for the GPIO interrupt block.
// The clock and reset travel with the bus so the slave sees one coherent port.
interface wb_gpio_irq_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic        ack;
    logic        stall;
    logic        err;

    modport slave (
        input  clk, rst, cyc, stb, we, adr, dat_i, sel,
        output dat_o, ack, stall, err
    );

    modport master (
        input  clk, rst, dat_o, ack, stall, err,
        output cyc, stb, we, adr, dat_i, sel
    );
endinterface

// File: rtl/wb_gpio_irq.sv
// Debounced GPIO edge detector with per-bit rise/fall enables, W1C pending
// flags and a level interrupt, behind a Wishbone pipelined slave.
module wb_gpio_irq #(
    parameter int size      = 32,
    parameter int cnt_width = 16
) (
    wb_gpio_irq_if.slave    wb,
    input  logic [size-1:0] pins,
    output logic            irq,
    output logic [size-1:0] level
);
    localparam logic [4:0] ADR_LEVEL    = 5'h00;
    localparam logic [4:0] ADR_RISE_EN  = 5'h04;
    localparam logic [4:0] ADR_FALL_EN  = 5'h08;
    localparam logic [4:0] ADR_PENDING  = 5'h0C;
    localparam logic [4:0] ADR_DEBOUNCE = 5'h10;

    logic [size-1:0]      sync1, sync2, sample, debounced, deb_prev;
    logic [size-1:0]      rise_en, fall_en, pending;
    logic [size-1:0]      rise, fall, pend_set, pend_clr, stable;
    logic [cnt_width-1:0] debounce, cnt;
    logic                 tick, req, wr, deb_wr;
    logic [31:0]          rd_data;
    logic                 unused_bits;

    assign req    = wb.cyc && wb.stb;
    assign wr     = req && wb.we;
    assign deb_wr = wr && (wb.adr[4:0] == ADR_DEBOUNCE);

    assign wb.stall = 1'b0;
    assign wb.err   = 1'b0;
    assign unused_bits = ^{wb.adr[31:5], wb.sel};

    // Pad levels are asynchronous; nothing but sync1 may look at them.
    // NOTE: every clocked register uses <= so all flops sample pre-edge values.
    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    // Prescaler counts 0..debounce and restarts whenever DEBOUNCE is written.
    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            cnt <= '0;
        end else if (deb_wr || debounce == '0 || cnt == debounce) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick   = (debounce != '0) && (cnt == debounce);
    assign stable = ~(sync2 ^ sample);

    // A bit only follows sync2 after two consecutive ticks saw the same value.
    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            sample    <= '0;
            debounced <= '0;
            deb_prev  <= '0;
        end else begin
            deb_prev <= debounced;
            if (debounce == '0) begin
                debounced <= sync2;
            end else if (tick) begin
                debounced <= (sync2 & stable) | (debounced & ~stable);
                sample    <= sync2;
            end
        end
    end

    assign rise     = debounced & ~deb_prev;
    assign fall     = ~debounced & deb_prev;
    assign pend_set = (rise & rise_en) | (fall & fall_en);
    assign pend_clr = (wr && wb.adr[4:0] == ADR_PENDING) ? wb.dat_i[size-1:0] : '0;

    // Clear is applied first so a coincident set on the same bit wins.
    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            rise_en  <= '0;
            fall_en  <= '0;
            debounce <= '0;
        end else if (wr) begin
            case (wb.adr[4:0])
                ADR_RISE_EN:  rise_en  <= wb.dat_i[size-1:0];
                ADR_FALL_EN:  fall_en  <= wb.dat_i[size-1:0];
                ADR_DEBOUNCE: debounce <= wb.dat_i[cnt_width-1:0];
                default: ;
            endcase
        end
    end

    // NOTE: rd_data gets a default before the case so no path infers a latch.
    always_comb begin
        rd_data = '0;
        case (wb.adr[4:0])
            ADR_LEVEL:    rd_data[size-1:0]      = debounced;
            ADR_RISE_EN:  rd_data[size-1:0]      = rise_en;
            ADR_FALL_EN:  rd_data[size-1:0]      = fall_en;
            ADR_PENDING:  rd_data[size-1:0]      = pending;
            ADR_DEBOUNCE: rd_data[cnt_width-1:0] = debounce;
            default: ;
        endcase
    end

    // Single-cycle ack; dat_o only moves on reads and holds otherwise.
    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            wb.ack   <= 1'b0;
            wb.dat_o <= '0;
        end else begin
            wb.ack <= req;
            if (req && !wb.we) begin
                wb.dat_o <= rd_data;
            end
        end
    end

    assign irq   = |pending;
    assign level = debounced;
endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed bench for wb_gpio_irq: register-map vector table followed by
// hand-timed sequences for edges, debounce, W1C race, bursts and reset.
module tb_wb_gpio_irq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pins = '0;
    logic        irq;
    logic [31:0] level;
    logic [31:0] rd;
    int          tests = 0;
    int          fails = 0;

    wb_gpio_irq_if wb (.clk(clk), .rst(rst));

    wb_gpio_irq #(.size(32), .cnt_width(16)) dut (
        .wb    (wb),
        .pins  (pins),
        .irq   (irq),
        .level (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // All tasks start and end 1 ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.adr = a; wb.dat_i = d;
        tick(1);
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        check($sformatf("write ack @%02h", a), {31'd0, wb.ack}, 32'd1);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = a;
        tick(1);
        wb.cyc = 1'b0; wb.stb = 1'b0;
        check($sformatf("read ack @%02h", a), {31'd0, wb.ack}, 32'd1);
        d = wb.dat_o;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h04, 1'b1, 32'hA5A5A5A5, 32'h0};
        vecs[1]  = '{32'h04, 1'b0, 32'h0,        32'hA5A5A5A5};
        vecs[2]  = '{32'h08, 1'b1, 32'h0F0F0000, 32'h0};
        vecs[3]  = '{32'h08, 1'b0, 32'h0,        32'h0F0F0000};
        vecs[4]  = '{32'h10, 1'b1, 32'h00012345, 32'h0};
        vecs[5]  = '{32'h10, 1'b0, 32'h0,        32'h00002345};
        vecs[6]  = '{32'h14, 1'b0, 32'h0,        32'h0};
        vecs[7]  = '{32'h1C, 1'b1, 32'hDEADBEEF, 32'h0};
        vecs[8]  = '{32'h1C, 1'b0, 32'h0,        32'h0};
        vecs[9]  = '{32'h00, 1'b1, 32'hFFFFFFFF, 32'h0};
        vecs[10] = '{32'h00, 1'b0, 32'h0,        32'h0};
        vecs[11] = '{32'h0C, 1'b0, 32'h0,        32'h0};
        vecs[12] = '{32'hFFFFFF04, 1'b0, 32'h0,  32'hA5A5A5A5};
        vecs[13] = '{32'h10, 1'b1, 32'h0,        32'h0};
        vecs[14] = '{32'h04, 1'b1, 32'h0,        32'h0};
        vecs[15] = '{32'h08, 1'b1, 32'h0,        32'h0};

        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        wb.adr = '0; wb.dat_i = '0; wb.sel = 4'hF;

        // Reset state
        tick(3);
        check("reset ack", {31'd0, wb.ack}, 32'd0);
        check("reset irq", {31'd0, irq}, 32'd0);
        check("reset level", level, 32'd0);
        check("reset dat_o", wb.dat_o, 32'd0);
        check("stall/err", {30'd0, wb.stall, wb.err}, 32'd0);
        rst = 1'b0;
        tick(1);

        // Register map table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].adr, vecs[i].dat);
            end else begin
                read_check($sformatf("vec%0d @%02h", i, vecs[i].adr), vecs[i].adr, vecs[i].exp);
            end
        end
        tick(1);
        check("idle ack", {31'd0, wb.ack}, 32'd0);
        check("table irq", {31'd0, irq}, 32'd0);

        // Bypass rising edge on pin 0
        bus_write(32'h04, 32'h1);
        pins[0] = 1'b1;
        tick(2);
        check("bypass level n+1", level, 32'h0);
        tick(1);
        check("bypass level n+2", level, 32'h1);
        check("bypass irq n+2", {31'd0, irq}, 32'd0);
        tick(1);
        check("bypass irq n+3", {31'd0, irq}, 32'd1);
        read_check("bypass pending", 32'h0C, 32'h1);
        read_check("bypass LEVEL", 32'h00, 32'h1);
        bus_write(32'h0C, 32'h1);
        check("w1c irq", {31'd0, irq}, 32'd0);

        // Falling edge only on pin 2
        bus_write(32'h04, 32'h0);
        pins[0] = 1'b0;
        tick(4);
        bus_write(32'h08, 32'h4);
        pins[2] = 1'b1;
        tick(5);
        check("fall-only no rise irq", {31'd0, irq}, 32'd0);
        read_check("fall-only after rise", 32'h0C, 32'h0);
        pins[2] = 1'b0;
        tick(5);
        read_check("fall-only after fall", 32'h0C, 32'h4);
        check("fall-only irq", {31'd0, irq}, 32'd1);
        bus_write(32'h0C, 32'h4);

        // Debounce reject then accept on pin 1
        bus_write(32'h04, 32'h2);
        bus_write(32'h10, 32'h3);
        pins[1] = 1'b1;
        tick(3);
        pins[1] = 1'b0;
        tick(16);
        check("debounce glitch level", level, 32'h0);
        read_check("debounce glitch pending", 32'h0C, 32'h0);
        pins[1] = 1'b1;
        tick(12);
        check("debounce held level", level, 32'h2);
        tick(3);
        read_check("debounce held pending", 32'h0C, 32'h2);

        // W1C clear racing a new enabled rise on bit 0
        bus_write(32'h10, 32'h0);
        bus_write(32'h04, 32'h3);
        pins[0] = 1'b1;
        tick(4);
        read_check("race setup pending", 32'h0C, 32'h3);
        pins[0] = 1'b0;
        tick(4);
        pins[0] = 1'b1;
        tick(3);
        bus_write(32'h0C, 32'h3);
        check("race irq", {31'd0, irq}, 32'd1);
        read_check("race pending", 32'h0C, 32'h1);

        // Back-to-back reads
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 32'h04;
        tick(1);
        check("burst ack0", {31'd0, wb.ack}, 32'd1);
        check("burst dat0", wb.dat_o, 32'h3);
        wb.adr = 32'h08;
        tick(1);
        check("burst ack1", {31'd0, wb.ack}, 32'd1);
        check("burst dat1", wb.dat_o, 32'h4);
        wb.adr = 32'h14;
        tick(1);
        check("burst ack2", {31'd0, wb.ack}, 32'd1);
        check("burst dat2", wb.dat_o, 32'h0);
        wb.cyc = 1'b0; wb.stb = 1'b0;
        tick(1);
        check("burst end ack", {31'd0, wb.ack}, 32'd0);

        // Reset in the middle of a read with all four pending
        bus_write(32'h04, 32'hF);
        pins[3:0] = 4'h0;
        tick(5);
        pins[3:0] = 4'hF;
        tick(5);
        read_check("pre-reset pending", 32'h0C, 32'hF);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 32'h0C;
        #2 rst = 1'b1;
        #1;
        check("reset-mid irq", {31'd0, irq}, 32'd0);
        check("reset-mid ack", {31'd0, wb.ack}, 32'd0);
        check("reset-mid level", level, 32'h0);
        @(posedge clk); #1;
        check("reset-mid ack after edge", {31'd0, wb.ack}, 32'd0);
        wb.cyc = 1'b0; wb.stb = 1'b0;
        pins = '0;
        tick(2);
        rst = 1'b0;
        tick(2);
        for (int a = 0; a <= 16; a += 4) begin
            read_check($sformatf("post-reset @%02h", a), 32'(a), 32'h0);
        end
        check("post-reset irq", {31'd0, irq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
